// File: rtl/soc_rtc_alarm.sv
// Multi-channel RTC alarm/compare controller: per-channel compare, periodic reload,
// wrap-safe "time reached" detection and a registered interrupt line.
module soc_rtc_alarm #(
  parameter int IO_MAP_WIDTH = 32,
  parameter int NUM_CH       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IO_MAP_WIDTH-1:0] rtc_time,
  input  logic                    rtc_ready,
  input  logic [3:0]              io_addr,
  input  logic [IO_MAP_WIDTH-1:0] io_wdata,
  input  logic                    io_we,
  input  logic                    io_re,
  output logic [IO_MAP_WIDTH-1:0] io_rdata,
  output logic                    io_ready,
  output logic [NUM_CH-1:0]       irq_vec,
  output logic                    irq
);

  localparam int W = IO_MAP_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  localparam logic [1:0] REG_CMP    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [1:0]   w_sel_ch;
  logic [1:0]   w_sel_reg;
  logic [W-1:0] w_cmp_rd    [4];
  logic [W-1:0] w_period_rd [4];
  logic [W-1:0] w_ctrl_rd   [4];
  logic [W-1:0] w_status_rd [4];
  logic [3:0]   w_irq_src;
  logic [W-1:0] w_rd_data;

  logic [W-1:0]      r_rdata;
  logic              r_ready;
  logic [NUM_CH-1:0] r_irq_vec;
  logic              r_irq;

  assign w_sel_ch  = io_addr[3:2];
  assign w_sel_reg = io_addr[1:0];

  // The decode is always four slots wide; slots beyond NUM_CH are tied to zero
  // so reads of absent channels return 0 and writes to them land nowhere.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      if (gi < NUM_CH) begin : g_live
        state_t       r_state;
        state_t       w_state_next;
        logic [W-1:0] r_cmp;
        logic [W-1:0] w_cmp_next;
        logic [W-1:0] r_period;
        logic         r_periodic;
        logic         r_irq_en;
        logic         r_pending;
        logic         w_pending_next;
        logic         w_hit;
        logic         w_wr_cmp;
        logic         w_wr_period;
        logic         w_wr_ctrl;
        logic         w_wr_status;
        logic         w_disable;
        logic [W-1:0] w_delta;
        logic         w_fire;
        logic         w_reload;

        assign w_hit       = io_we && (w_sel_ch == 2'(gi));
        assign w_wr_cmp    = w_hit && (w_sel_reg == REG_CMP);
        assign w_wr_period = w_hit && (w_sel_reg == REG_PERIOD);
        assign w_wr_ctrl   = w_hit && (w_sel_reg == REG_CTRL);
        assign w_wr_status = w_hit && (w_sel_reg == REG_STATUS);
        assign w_disable   = w_wr_ctrl && !io_wdata[0];

        // Time has reached CMP when the modular difference is in the lower half-range.
        assign w_delta  = rtc_time - r_cmp;
        assign w_fire   = (r_state == ST_ARMED) && rtc_ready && !w_delta[W-1] && !w_disable;
        assign w_reload = w_fire && r_periodic && (r_period != '0);

        always_ff @(posedge clk) begin
          if (rst) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= w_state_next;
          end
        end

        always_comb begin
          w_state_next   = r_state;
          w_cmp_next     = r_cmp;
          w_pending_next = r_pending;
          if (w_wr_ctrl) begin
            w_state_next = io_wdata[0] ? ST_ARMED : ST_IDLE;
          end else if (w_fire && !w_reload) begin
            w_state_next = ST_FIRED;
          end
          // A software CMP write overrides the reload computed in the same cycle.
          if (w_wr_cmp) begin
            w_cmp_next = io_wdata;
          end else if (w_reload) begin
            w_cmp_next = r_cmp + r_period;
          end
          if (w_fire) begin
            w_pending_next = 1'b1;
          end else if (w_wr_status && io_wdata[0]) begin
            w_pending_next = 1'b0;
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_cmp      <= '0;
            r_period   <= '0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
            r_pending  <= 1'b0;
          end else begin
            r_cmp     <= w_cmp_next;
            r_pending <= w_pending_next;
            if (w_wr_period) begin
              r_period <= io_wdata;
            end
            if (w_wr_ctrl) begin
              r_periodic <= io_wdata[1];
              r_irq_en   <= io_wdata[2];
            end
          end
        end

        assign w_cmp_rd[gi]    = r_cmp;
        assign w_period_rd[gi] = r_period;
        assign w_ctrl_rd[gi]   = {{(W-3){1'b0}}, r_irq_en, r_periodic, (r_state == ST_ARMED)};
        assign w_status_rd[gi] = {{(W-3){1'b0}}, r_state, r_pending};
        assign w_irq_src[gi]   = r_pending & r_irq_en;
      end else begin : g_tie
        assign w_cmp_rd[gi]    = '0;
        assign w_period_rd[gi] = '0;
        assign w_ctrl_rd[gi]   = '0;
        assign w_status_rd[gi] = '0;
        assign w_irq_src[gi]   = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    case (w_sel_reg)
      REG_CMP:    w_rd_data = w_cmp_rd[w_sel_ch];
      REG_PERIOD: w_rd_data = w_period_rd[w_sel_ch];
      REG_CTRL:   w_rd_data = w_ctrl_rd[w_sel_ch];
      default:    w_rd_data = w_status_rd[w_sel_ch];
    endcase
  end

  // Read data is sampled before this edge's write, so a same-cycle read sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_irq_vec <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_ready   <= io_we | io_re;
      r_irq_vec <= w_irq_src[NUM_CH-1:0];
      r_irq     <= |w_irq_src[NUM_CH-1:0];
      if (io_re) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  assign io_rdata = r_rdata;
  assign io_ready = r_ready;
  assign irq_vec  = r_irq_vec;
  assign irq      = r_irq;

endmodule

// File: tb/tb_soc_rtc_alarm.sv
// Directed and randomized bench for soc_rtc_alarm with a behavioural channel model.
module tb_soc_rtc_alarm;
  localparam int W   = 32;
  localparam int NCH = 4;
  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_FIRED = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   rtc_time;
  logic           rtc_ready;
  logic [3:0]     io_addr;
  logic [W-1:0]   io_wdata;
  logic           io_we;
  logic           io_re;
  logic [W-1:0]   io_rdata;
  logic           io_ready;
  logic [NCH-1:0] irq_vec;
  logic           irq;

  always #5 clk = ~clk;

  soc_rtc_alarm #(.IO_MAP_WIDTH(W), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .rtc_time(rtc_time), .rtc_ready(rtc_ready),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
    .io_rdata(io_rdata), .io_ready(io_ready), .irq_vec(irq_vec), .irq(irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model of the register file and channel behaviour.
  logic [W-1:0]   m_cmp [NCH];
  logic [W-1:0]   m_per [NCH];
  int             m_state [NCH];
  bit             m_periodic [NCH];
  bit             m_irq_en [NCH];
  bit             m_pending [NCH];
  logic [NCH-1:0] m_vec;
  logic [W-1:0]   m_rdata;

  logic [W-1:0] cur_t;
  bit           cur_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int ch;
    logic [31:0] v;
    ch = int'(a[3:2]);
    v  = '0;
    if (ch < NCH) begin
      case (a[1:0])
        2'd0:    v = m_cmp[ch];
        2'd1:    v = m_per[ch];
        2'd2:    v = {29'd0, m_irq_en[ch], m_periodic[ch], (m_state[ch] == S_ARMED)};
        default: v = 32'(m_state[ch] * 2 + int'(m_pending[ch]));
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input logic [31:0] t, input bit rdy, input bit we, input bit re,
                            input logic [3:0] a, input logic [31:0] d);
    logic [NCH-1:0] nv;
    if (re) m_rdata = model_read(a);
    for (int ch = 0; ch < NCH; ch++) begin
      bit mine;
      bit killed;
      bit fire;
      mine   = we && (int'(a[3:2]) == ch);
      nv[ch] = m_pending[ch] && m_irq_en[ch];
      killed = mine && (a[1:0] == 2'd2) && !d[0];
      fire   = (m_state[ch] == S_ARMED) && rdy && (int'(t - m_cmp[ch]) >= 0) && !killed;
      if (fire) begin
        m_pending[ch] = 1'b1;
        if (m_periodic[ch] && m_per[ch] != 0) m_cmp[ch] = m_cmp[ch] + m_per[ch];
        else m_state[ch] = S_FIRED;
      end
      if (mine) begin
        case (a[1:0])
          2'd0: m_cmp[ch] = d;
          2'd1: m_per[ch] = d;
          2'd2: begin
            m_state[ch]    = d[0] ? S_ARMED : S_IDLE;
            m_periodic[ch] = d[1];
            m_irq_en[ch]   = d[2];
          end
          default: if (d[0] && !fire) m_pending[ch] = 1'b0;
        endcase
      end
    end
    m_vec = nv;
  endtask

  task automatic step(input logic [31:0] t, input bit rdy, input bit we, input bit re,
                      input logic [3:0] a, input logic [31:0] d);
    rtc_time = t; rtc_ready = rdy; io_we = we; io_re = re; io_addr = a; io_wdata = d;
    @(posedge clk);
    model_edge(t, rdy, we, re, a, d);
    #1;
    $display("step t=0x%08h rdy=%0d we=%0d re=%0d addr=%0h wdata=0x%0h -> rdata=0x%0h ready=%0d irq_vec=%b irq=%0d",
             t, rdy, we, re, a, d, io_rdata, io_ready, irq_vec, irq);
    chk("io_ready", 32'(io_ready), 32'(we | re));
    chk("io_rdata", io_rdata, m_rdata);
    chk("irq_vec", 32'(irq_vec), 32'(m_vec));
    chk("irq", 32'(irq), 32'(|m_vec));
  endtask

  task automatic tick();
    step(cur_t, cur_rdy, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(cur_t, cur_rdy, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    step(cur_t, cur_rdy, 1'b0, 1'b1, a, 32'h0);
    chk(tag, io_rdata, exp);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; io_we = 1'b0; io_re = 1'b0; rtc_ready = 1'b0;
    io_addr = '0; io_wdata = '0; rtc_time = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_cmp[ch] = '0; m_per[ch] = '0; m_state[ch] = S_IDLE;
      m_periodic[ch] = 1'b0; m_irq_en[ch] = 1'b0; m_pending[ch] = 1'b0;
    end
    m_vec = '0; m_rdata = '0;
    cur_t = '0; cur_rdy = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      $display("reset cycle irq=%0d ready=%0d rdata=0x%0h", irq, io_ready, io_rdata);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_irq_vec", 32'(irq_vec), 32'd0);
      chk("rst_ready", 32'(io_ready), 32'd0);
      chk("rst_rdata", io_rdata, 32'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; io_we = 1'b0; io_re = 1'b0; rtc_ready = 1'b0;
    io_addr = '0; io_wdata = '0; rtc_time = '0;
    do_reset(2);
    for (int a = 0; a < 16; a++) rd("rst_read", 4'(a), 32'd0);

    // One-shot on channel 0
    wr(4'h0, 32'd100);
    wr(4'h2, 32'd5);
    cur_rdy = 1'b1;
    for (int t = 90; t <= 110; t++) begin
      cur_t = 32'(t);
      tick();
      chk("os_irq", 32'(irq), 32'(t >= 101));
    end
    cur_rdy = 1'b0;
    rd("os_status", 4'h3, 32'd5);
    rd("os_ctrl", 4'h2, 32'd4);
    wr(4'h3, 32'd1);
    chk("os_irq_hold", 32'(irq), 32'd1);
    tick();
    chk("os_irq_clr", 32'(irq), 32'd0);

    // Periodic on channel 1: fires at 10, 15, 20
    wr(4'h4, 32'd10);
    wr(4'h5, 32'd5);
    wr(4'h6, 32'd7);
    for (int t = 8; t <= 22; t++) begin
      cur_t = 32'(t);
      step(cur_t, 1'b1, 1'b0, 1'b1, 4'h4, 32'h0);
      chk("per_cmp", io_rdata, (t <= 10) ? 32'd10 : (t <= 15) ? 32'd15 : (t <= 20) ? 32'd20 : 32'd25);
    end
    rd("per_cmp_end", 4'h4, 32'd25);
    rd("per_status", 4'h7, 32'd3);
    wr(4'h6, 32'd0);
    wr(4'h7, 32'd1);
    rd("per_idle", 4'h7, 32'd0);

    // Wrap-around on channel 2
    wr(4'h8, 32'hFFFF_FFFE);
    wr(4'h9, 32'd4);
    wr(4'hA, 32'd3);
    for (int k = 0; k < 9; k++) begin
      cur_t = 32'hFFFF_FFFC + 32'(k);
      if (k == 1) begin
        step(cur_t, 1'b1, 1'b0, 1'b1, 4'hB, 32'h0);
        chk("wrap_nofire", io_rdata, 32'd2);
      end else begin
        step(cur_t, 1'b1, 1'b0, 1'b1, 4'h8, 32'h0);
        chk("wrap_cmp", io_rdata, (k <= 2) ? 32'hFFFF_FFFE : (k <= 6) ? 32'd2 : 32'd6);
      end
    end
    wr(4'hA, 32'd0);
    wr(4'hB, 32'd1);

    // Channel 3: W1C racing a fire, then CMP write racing a reload
    wr(4'hC, 32'd999);
    wr(4'hD, 32'd1);
    wr(4'hE, 32'd7);
    step(32'd999, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    step(32'd1000, 1'b1, 1'b1, 1'b0, 4'hF, 32'd1);
    cur_t = 32'd1000;
    rd("w1c_set_wins", 4'hF, 32'd3);
    wr(4'hF, 32'd1);
    rd("w1c_clear", 4'hF, 32'd2);
    step(32'd1001, 1'b1, 1'b1, 1'b0, 4'hC, 32'd5000);
    cur_t = 32'd1001;
    rd("cmpwr_wins", 4'hC, 32'd5000);
    rd("cmpwr_pend", 4'hF, 32'd3);
    wr(4'hE, 32'd0);
    wr(4'hF, 32'd1);

    // rtc_ready gating, then disable racing a fire
    wr(4'h0, 32'd50);
    wr(4'h2, 32'd5);
    cur_t = 32'd1060;
    repeat (5) begin
      tick();
      chk("gate_irq", 32'(irq), 32'd0);
    end
    rd("gate_status", 4'h3, 32'd2);
    step(cur_t, 1'b1, 1'b1, 1'b0, 4'h2, 32'd0);
    rd("dis_status", 4'h3, 32'd0);
    tick();
    chk("dis_irq", 32'(irq), 32'd0);

    // Same-cycle write and read returns the old value
    step(cur_t, 1'b0, 1'b1, 1'b1, 4'h0, 32'd123);
    chk("rw_pre", io_rdata, 32'd50);
    rd("rw_post", 4'h0, 32'd123);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      int          op;
      cur_t   = cur_t + 32'($urandom_range(0, 3));
      cur_rdy = ($urandom_range(0, 3) != 0);
      a       = 4'($urandom_range(0, 15));
      op      = int'($urandom_range(0, 3));
      case (a[1:0])
        2'd0:    d = cur_t + 32'($urandom_range(0, 24));
        2'd1:    d = 32'($urandom_range(0, 6));
        2'd2:    d = 32'($urandom_range(0, 7));
        default: d = 32'($urandom_range(0, 1));
      endcase
      step(cur_t, cur_rdy, (op == 1) || (op == 3), (op == 2) || (op == 3), a, d);
    end

    // Reset mid-operation cancels an in-flight read acknowledge
    wr(4'h0, 32'd7);
    rd("pre_rst_read", 4'h0, 32'd7);
    io_re = 1'b1; io_addr = 4'h0; rst = 1'b1;
    @(posedge clk);
    #1;
    $display("mid reset ready=%0d rdata=0x%0h irq=%0d", io_ready, io_rdata, irq);
    chk("rst_mid_ready", 32'(io_ready), 32'd0);
    chk("rst_mid_rdata", io_rdata, 32'd0);
    do_reset(1);
    for (int a = 0; a < 16; a++) rd("rst2_read", 4'(a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_rtc_alarm.md
# soc_rtc_alarm

Multi-channel alarm/compare controller that schedules interrupts against the free-running RTC count. It sits on the IO bus next to the RTC block and consumes the RTC read data and ready already in the `clk` domain. Software programs per-channel compare and period registers; the block arms channels, detects when RTC time reaches each compare value (wrap-safe), reloads periodic channels, and raises a registered interrupt line.

## Interface
- `IO_MAP_WIDTH`, 32: data width of RTC time, compare, period and IO data.
- `NUM_CH`, 4: number of alarm channels, 1..4.
- `clk`  in  1: system clock; the block has one clock.
- `rst`  in  1: synchronous, active-high reset.
- `rtc_time`  in  IO_MAP_WIDTH: current RTC count, `clk` domain.
- `rtc_ready`  in  1: `rtc_time` is valid this cycle.
- `io_addr`  in  4: bits[3:2] channel, bits[1:0] register.
- `io_wdata`  in  IO_MAP_WIDTH: write data.
- `io_we`  in  1: write strobe, single cycle.
- `io_re`  in  1: read strobe, single cycle.
- `io_rdata`  out  IO_MAP_WIDTH: read data.
- `io_ready`  out  1: read/write acknowledge pulse.
- `irq_vec`  out  NUM_CH: per-channel `pending & irq_en`, registered.
- `irq`  out  1: OR of `irq_vec`, registered.

## Operation
- Register map per channel: 0 `CMP`, 1 `PERIOD`, 2 `CTRL`, 3 `STATUS`.
- `CTRL` bits: [0] `enable`, [1] `periodic`, [2] `irq_en`. Other bits read 0.
- `STATUS` bits: [0] `pending`, write 1 to clear. Bits [2:1] hold the state: 0 IDLE, 1 ARMED, 2 FIRED. Writes to [2:1] are ignored.
- Accesses to channels >= `NUM_CH` are ignored on write and read 0. They still get `io_ready`.
- Per-channel FSM:
  - IDLE -> ARMED on a `CTRL` write with `enable`=1.
  - Any state -> IDLE on a `CTRL` write with `enable`=0. `pending` is kept.
  - A `CTRL` write with `enable`=1 in FIRED re-arms the channel.
- Fire condition: state ARMED, `rtc_ready`=1, and MSB of (`rtc_time` - `CMP`) mod 2^W is 0, i.e. time has reached `CMP` within half-range. Compare runs only on `rtc_ready` cycles.
- On fire:
  - `pending` <= 1.
  - If `periodic`=1 and `PERIOD`!=0: `CMP` <= `CMP` + `PERIOD` mod 2^W, stay ARMED.
  - Otherwise -> FIRED, and `enable` reads back 0.
- Missed periods: if the reloaded `CMP` is still in the past, the channel fires again on the next `rtc_ready` cycle. At most one fire per channel per cycle; no catch-up counter.
- Simultaneous events:
  - Software `CMP` write in the same cycle as a fire reload: the write wins, and `pending` still sets.
  - W1C and a new fire in the same cycle: the set wins, `pending`=1.
  - `CTRL` disable in the same cycle as a fire: the disable wins, and `pending` is not set.
- Writing `CMP` while ARMED takes effect for the next compare cycle.

## Timing
- Reset: all registers, `pending`, state IDLE, `io_rdata`=0, `io_ready`=0, `irq_vec`=0, `irq`=0.
- Write: takes effect at the clock edge where `io_we`=1. `io_ready`=1 in the next cycle.
- Read: `io_rdata` is valid together with `io_ready`=1 in the cycle after `io_re`. `io_rdata` holds its value until the next read.
- `io_we` and `io_re` in the same cycle: the write is performed, and the read returns the pre-write value.
- Fire: `pending` visible in `STATUS` 1 cycle after the `rtc_ready` compare edge. `irq_vec`/`irq` follow 1 cycle after `pending`, so 2 cycles total.
- `irq` drops 2 cycles after a W1C clear or an `irq_en`=0 write.
- `rst` asserted mid-operation: everything returns to reset values at that edge, including any in-flight read acknowledge.

## Test plan
- Reset value check:
  - Stimulus: assert `rst` 2 cycles, then read all 16 addresses.
  - Required: all reads = 0, `irq`=0 throughout.
- One-shot channel 0:
  - Stimulus: `CMP`=100, `CTRL`=0b101, ramp `rtc_time` 90..110 with `rtc_ready`=1.
  - Required: `pending` set after time 100, `irq`=1 two cycles after the time-100 edge, state FIRED, `CTRL` reads 0b100. Clearing `STATUS` with 1 drops `irq`.
- Periodic channel 1:
  - Stimulus: `CMP`=10, `PERIOD`=5, `CTRL`=0b111.
  - Required: fires at 10, 15, 20; `CMP` reads 25 after the third fire; state stays ARMED.
- Wrap-around:
  - Stimulus: `CMP`=0xFFFFFFFE, `PERIOD`=4, periodic; time runs 0xFFFFFFFC..0x00000004.
  - Required: fire at 0xFFFFFFFE, `CMP` becomes 0x00000002, then a fire at 0x2. No fire at 0xFFFFFFFC.
- Simultaneous W1C and fire:
  - Stimulus: periodic `PERIOD`=1; write `STATUS`=1 in the same cycle as a fire.
  - Required: `pending` remains 1.
- `rtc_ready` gating and disable:
  - Stimulus: `rtc_time` ≥ `CMP` with `rtc_ready`=0 for 5 cycles; then `CTRL`=0 written in the same cycle `rtc_ready` rises.
  - Required: no fire, state IDLE, `pending`=0.
